// File: rtl/ring_buffer_uart_tx_if.sv
// Read side of the transmit ring buffer: one-cycle read request, registered ack and data.
interface ring_buffer_uart_tx_if #(
    parameter int WordSize = 8
);
    logic                dataReadEnable;
    logic                dataReadAck;
    logic [WordSize-1:0] dataRead;

    modport master (
        output dataReadEnable,
        input  dataReadAck,
        input  dataRead
    );

    modport slave (
        input  dataReadEnable,
        output dataReadAck,
        output dataRead
    );
endinterface

// File: rtl/ring_buffer_uart_tx.sv
// Drains words from a ring buffer over its read-enable/ack handshake and
// shifts each one out as an 8N1-style serial frame, LSB first.
module ring_buffer_uart_tx #(
    parameter int WordSize     = 8,
    parameter int ClocksPerBit = 434,
    parameter int RetryDelay   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    ring_buffer_uart_tx_if.master rb,
    output logic                  txd,
    output logic                  busy,
    output logic [31:0]           byteCount
);
    localparam int CycleW = (ClocksPerBit > 1) ? $clog2(ClocksPerBit) : 1;
    localparam int BitW   = (WordSize > 1) ? $clog2(WordSize) : 1;
    localparam int RetryW = (RetryDelay > 1) ? $clog2(RetryDelay) : 1;

    localparam logic [CycleW-1:0] CycleLast = CycleW'(ClocksPerBit - 1);
    localparam logic [BitW-1:0]   BitLast   = BitW'(WordSize - 1);
    localparam logic [RetryW-1:0] RetryLast = RetryW'(RetryDelay - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        BACKOFF,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state_reg,  state_next;
    logic [CycleW-1:0]     cycle_reg,  cycle_next;
    logic [BitW-1:0]       bit_reg,    bit_next;
    logic [RetryW-1:0]     retry_reg,  retry_next;
    logic [WordSize-1:0]   shift_reg,  shift_next;
    logic [31:0]           count_reg,  count_next;
    logic                  txd_reg,    txd_next;
    logic                  rd_en_reg,  rd_en_next;
    logic                  bit_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cycle_reg <= '0;
            bit_reg   <= '0;
            retry_reg <= '0;
            shift_reg <= '0;
            count_reg <= '0;
            txd_reg   <= 1'b1;
            rd_en_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cycle_reg <= cycle_next;
            bit_reg   <= bit_next;
            retry_reg <= retry_next;
            shift_reg <= shift_next;
            count_reg <= count_next;
            txd_reg   <= txd_next;
            rd_en_reg <= rd_en_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cycle_next = cycle_reg;
        bit_next   = bit_reg;
        retry_next = retry_reg;
        shift_next = shift_reg;
        count_next = count_reg;
        bit_end    = (cycle_reg == CycleLast);

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                state_next = WAIT;
            end
            WAIT: begin
                // The buffer's ack is registered, so it is valid here, one cycle after the request.
                if (rb.dataReadAck) begin
                    shift_next = rb.dataRead;
                    cycle_next = '0;
                    state_next = START;
                end else begin
                    retry_next = '0;
                    state_next = BACKOFF;
                end
            end
            BACKOFF: begin
                if (retry_reg == RetryLast) begin
                    state_next = enable ? REQ : IDLE;
                end else begin
                    retry_next = retry_reg + 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    cycle_next = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    cycle_next = cycle_reg + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cycle_next = '0;
                    shift_next = shift_reg >> 1;
                    if (bit_reg == BitLast) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end else begin
                    cycle_next = cycle_reg + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cycle_next = '0;
                    count_next = count_reg + 1'b1;
                    state_next = enable ? REQ : IDLE;
                end else begin
                    cycle_next = cycle_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line level is decoded from the current state and registered, so txd
    // trails the state/counter change by one cycle and never glitches.
    always_comb begin
        txd_next = 1'b1;
        case (state_reg)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_reg[0];
            default: txd_next = 1'b1;
        endcase
    end

    // Registered request that is high exactly while the state register holds REQ.
    always_comb begin
        rd_en_next = (state_next == REQ);
    end

    assign rb.dataReadEnable = rd_en_reg;
    assign txd               = txd_reg;
    assign busy              = (state_reg == START) || (state_reg == DATA) || (state_reg == STOP);
    assign byteCount         = count_reg;
endmodule

// File: tb/tb_ring_buffer_uart_tx.sv
// Bench for ring_buffer_uart_tx: queue-based ring buffer model feeding the DUT,
// independent serial receiver checking frames against a scoreboard queue.
module tb_ring_buffer_uart_tx;
    localparam int Cpb   = 4;
    localparam int Retry = 3;
    localparam int FrameCycles = 10 * Cpb;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        txd;
    logic        busy;
    logic [31:0] byteCount;
    logic        wr_req;
    logic [7:0]  wr_data;

    ring_buffer_uart_tx_if #(.WordSize(8)) rb ();

    ring_buffer_uart_tx #(
        .WordSize(8),
        .ClocksPerBit(Cpb),
        .RetryDelay(Retry)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .rb(rb),
        .txd(txd),
        .busy(busy),
        .byteCount(byteCount)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int req_count = 0;
    int ack_count = 0;
    int frames_rx = 0;
    int frames_base = 0;
    int exp_frames = 0;
    int rst_events = 0;
    int req_times[$];
    int gap_q[$];
    logic [7:0] buf_q[$];
    logic [7:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge reset);
        rst_events++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Ring buffer model: write has priority over a read on the same edge.
    initial begin
        rb.dataReadAck = 1'b0;
        rb.dataRead    = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                rb.dataReadAck <= 1'b0;
            end else begin
                rb.dataReadAck <= 1'b0;
                if (wr_req) begin
                    buf_q.push_back(wr_data);
                end else if (rb.dataReadEnable && buf_q.size() != 0) begin
                    rb.dataReadAck <= 1'b1;
                    rb.dataRead    <= buf_q.pop_front();
                end
            end
        end
    end

    // Handshake and busy observer.
    initial begin
        int busy_run = 0;
        int low_run = 0;
        bit seen_busy = 0;
        bit prev_rd = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_run = 0;
                low_run = 0;
                seen_busy = 0;
                prev_rd = 0;
            end else begin
                if (rb.dataReadEnable === 1'b1) begin
                    check("req_single_cycle", 64'(prev_rd), 64'd0);
                    req_count++;
                    req_times.push_back(cyc);
                end
                prev_rd = (rb.dataReadEnable === 1'b1);
                if (rb.dataReadAck === 1'b1) ack_count++;
                if (busy === 1'b1) begin
                    if (busy_run == 0 && seen_busy) gap_q.push_back(low_run);
                    busy_run++;
                    low_run = 0;
                    seen_busy = 1;
                end else begin
                    if (busy_run != 0) check("busy_width", 64'(busy_run), 64'(FrameCycles));
                    busy_run = 0;
                    low_run++;
                end
            end
        end
    end

    // Serial receiver: samples each bit in its middle.
    task automatic rx_frame();
        logic [7:0] w;
        logic [7:0] e;
        logic start_b;
        logic stop_b;
        int r0;
        r0 = rst_events;
        w = '0;
        repeat (Cpb / 2) @(negedge clk);
        start_b = txd;
        for (int i = 0; i < 8; i++) begin
            repeat (Cpb) @(negedge clk);
            w[i] = txd;
        end
        repeat (Cpb) @(negedge clk);
        stop_b = txd;
        if (rst_events != r0) begin
            $display("rx frame cut short by reset");
            return;
        end
        check("start_bit", 64'(start_b), 64'd0);
        check("stop_bit", 64'(stop_b), 64'd1);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: got %02h, required no frame", w);
        end else begin
            e = exp_q.pop_front();
            check("frame_data", 64'(w), 64'(e));
        end
        frames_rx++;
        $display("rx frame %0d data 0x%02h", frames_rx - frames_base, w);
        @(negedge clk);
        if (rst_events == r0) check("byteCount_frame", 64'(byteCount), 64'(frames_rx - frames_base));
    endtask

    initial forever begin
        @(negedge clk);
        if (reset === 1'b0 && txd === 1'b0) rx_frame();
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_word(input logic [7:0] w);
        wr_req  = 1'b1;
        wr_data = w;
        exp_q.push_back(w);
        exp_frames++;
        @(negedge clk);
        wr_req = 1'b0;
    endtask

    task automatic wait_busy(input int limit);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("busy_timeout", 64'(busy), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int a0;
        int n;
        int unsigned r;
        reset   = 1'b1;
        enable  = 1'b0;
        wr_req  = 1'b0;
        wr_data = '0;

        // Reset values
        wait_cycles(3);
        check("rst_txd", 64'(txd), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_byteCount", 64'(byteCount), 64'd0);
        check("rst_rd_en", 64'(rb.dataReadEnable), 64'd0);
        reset = 1'b0;
        frames_base = frames_rx;
        wait_cycles(10);
        check("idle_no_req", 64'(req_count), 64'd0);

        // Single byte
        write_word(8'hA5);
        r0 = req_count;
        enable = 1'b1;
        wait_busy(20);
        enable = 1'b0;
        wait_cycles(60);
        check("single_req", 64'(req_count - r0), 64'd1);
        check("single_count", 64'(byteCount), 64'(exp_frames));

        // Empty buffer retries
        req_times.delete();
        a0 = ack_count;
        enable = 1'b1;
        wait_cycles(32);
        enable = 1'b0;
        wait_cycles(10);
        check("empty_req_pulses", 64'(req_times.size() >= 5), 64'd1);
        for (int i = 1; i < 5 && i < req_times.size(); i++)
            check("empty_req_period", 64'(req_times[i] - req_times[i-1]), 64'(2 + Retry));
        check("empty_no_ack", 64'(ack_count - a0), 64'd0);
        check("empty_count", 64'(byteCount), 64'(exp_frames));

        // Streaming
        write_word(8'h01);
        write_word(8'h02);
        write_word(8'h03);
        gap_q.delete();
        r0 = req_count;
        enable = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("stream_drained", 64'(exp_q.size()), 64'd0);
        wait_cycles(12);
        check("stream_retries", 64'((req_count - r0) >= 4), 64'd1);
        enable = 1'b0;
        wait_cycles(20);
        check("stream_gap_count", 64'(gap_q.size()), 64'd3);
        if (gap_q.size() >= 3) begin
            check("stream_gap1", 64'(gap_q[1]), 64'd2);
            check("stream_gap2", 64'(gap_q[2]), 64'd2);
        end
        check("stream_count", 64'(byteCount), 64'(exp_frames));

        // Lost request: write lands on the same edge as the request
        enable = 1'b1;
        n = 0;
        while (rb.dataReadEnable !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("lost_req_seen", 64'(rb.dataReadEnable), 64'd1);
        wr_req  = 1'b1;
        wr_data = 8'h77;
        exp_q.push_back(8'h77);
        exp_frames++;
        #1;
        r0 = req_count;
        a0 = ack_count;
        @(negedge clk);
        wr_req = 1'b0;
        wait_busy(40);
        enable = 1'b0;
        wait_cycles(60);
        check("lost_retry_req", 64'(req_count - r0), 64'd1);
        check("lost_ack_once", 64'(ack_count - a0), 64'd1);
        check("lost_count", 64'(byteCount), 64'(exp_frames));

        // Enable drop during bit 3
        write_word(8'h3C);
        r0 = req_count;
        enable = 1'b1;
        wait_busy(20);
        wait_cycles(Cpb + 3 * Cpb + 2);
        enable = 1'b0;
        wait_cycles(80);
        check("drop_req", 64'(req_count - r0), 64'd1);
        check("drop_count", 64'(byteCount), 64'(exp_frames));

        // Randomised writes and enable toggling
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r < 5) write_word(8'($urandom));
            else if (r < 7) enable = ~enable;
            wait_cycles(int'($urandom_range(1, 30)));
        end
        enable = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("random_drained", 64'(exp_q.size()), 64'd0);
        wait_cycles(5);
        enable = 1'b0;
        wait_cycles(60);
        check("random_count", 64'(byteCount), 64'(exp_frames));

        // Reset mid-DATA
        write_word(8'h5A);
        enable = 1'b1;
        wait_busy(20);
        wait_cycles(10);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_txd", 64'(txd), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_byteCount", 64'(byteCount), 64'd0);
        check("midrst_rd_en", 64'(rb.dataReadEnable), 64'd0);
        enable = 1'b0;
        void'(exp_q.pop_front());
        exp_frames = 0;
        wait_cycles(2);
        reset = 1'b0;
        frames_base = frames_rx;
        r0 = req_count;
        wait_cycles(45);
        check("postrst_no_req", 64'(req_count - r0), 64'd0);
        check("postrst_count", 64'(byteCount), 64'd0);

        // Restart from IDLE after reset
        write_word(8'h99);
        enable = 1'b1;
        wait_busy(20);
        enable = 1'b0;
        wait_cycles(60);
        check("restart_count", 64'(byteCount), 64'(exp_frames));
        check("restart_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
